// File: rtl/alu_isa_pkg.sv
// Shared ISA definitions for the 16-bit core execute path.
// Holds opcode class/ext constants, the sequencer state enum, flag bit indices
// and small opcode helpers used by the sequencer and its operand steering.
package alu_isa_pkg;

  // Instruction classes, op[7:4]
  localparam logic [3:0] CL_RTYPE = 4'b0000;
  localparam logic [3:0] CL_ANDI  = 4'b0001;
  localparam logic [3:0] CL_ORI   = 4'b0010;
  localparam logic [3:0] CL_XORI  = 4'b0011;
  localparam logic [3:0] CL_ADDI  = 4'b0101;
  localparam logic [3:0] CL_ADDUI = 4'b0110;
  localparam logic [3:0] CL_SHIFT = 4'b1000;
  localparam logic [3:0] CL_SUBI  = 4'b1001;
  localparam logic [3:0] CL_CMPI  = 4'b1011;
  localparam logic [3:0] CL_MOVI  = 4'b1101;
  localparam logic [3:0] CL_LUI   = 4'b1111;

  // Register-register extension codes, op[3:0] when class is RTYPE
  localparam logic [3:0] EX_AND  = 4'b0001;
  localparam logic [3:0] EX_OR   = 4'b0010;
  localparam logic [3:0] EX_XOR  = 4'b0011;
  localparam logic [3:0] EX_ADD  = 4'b0101;
  localparam logic [3:0] EX_ADDU = 4'b0110;
  localparam logic [3:0] EX_ADDC = 4'b0111;
  localparam logic [3:0] EX_SUB  = 4'b1001;
  localparam logic [3:0] EX_SUBC = 4'b1010;
  localparam logic [3:0] EX_CMP  = 4'b1011;
  localparam logic [3:0] EX_MOV  = 4'b1101;

  // Shift extension codes, op[3:0] when class is SHIFT
  localparam logic [3:0] EX_LSH  = 4'b0100;
  localparam logic [3:0] EX_ASHU = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Bit positions inside the 5-bit flag / psr vector {C, L, F, Z, N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  // Compares set flags only; they never write a register.
  function automatic logic is_cmp(input logic [7:0] op);
    return (op == {CL_RTYPE, EX_CMP}) || (op[7:4] == CL_CMPI);
  endfunction

  // Which psr fields an opcode is allowed to update.
  function automatic logic [4:0] psr_mask(input logic [7:0] op);
    logic [4:0] m;
    m = '0;
    if (is_cmp(op)) begin
      m[FLAG_L] = 1'b1;
      m[FLAG_Z] = 1'b1;
      m[FLAG_N] = 1'b1;
    end else if (op == {CL_RTYPE, EX_ADD} || op == {CL_RTYPE, EX_SUB} ||
                 op[7:4] == CL_ADDI || op[7:4] == CL_SUBI) begin
      m[FLAG_C] = 1'b1;
      m[FLAG_F] = 1'b1;
      m[FLAG_N] = 1'b1;
    end else if (op == {CL_RTYPE, EX_ADDU} || op == {CL_RTYPE, EX_ADDC} ||
                 op[7:4] == CL_ADDUI) begin
      m[FLAG_C] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_exec_sequencer_operand_mux.sv
// Operand steering for the ALU: picks register data or the extended immediate
// per instruction class, and flags classes the ALU does not support.
// Ports: op_class_i/imm_i/rdata_*_i in; src_o/dst_o steered operands, illegal_o out. Purely combinational.
module alu_operand_mux
  import alu_isa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMMW  = 8
) (
  input  logic [3:0]       op_class_i,
  input  logic [IMMW-1:0]  imm_i,
  input  logic [WIDTH-1:0] rdata_a_i,
  input  logic [WIDTH-1:0] rdata_b_i,
  output logic [WIDTH-1:0] src_o,
  output logic [WIDTH-1:0] dst_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_zext;

  assign imm_sext = {{(WIDTH-IMMW){imm_i[IMMW-1]}}, imm_i};
  assign imm_zext = {{(WIDTH-IMMW){1'b0}}, imm_i};

  always_comb begin
    src_o     = '0;
    dst_o     = '0;
    illegal_o = 1'b0;
    case (op_class_i)
      CL_RTYPE, CL_SHIFT: begin
        src_o = rdata_b_i;
        dst_o = rdata_a_i;
      end
      // Immediate loads carry the value in the dest operand; src is unused.
      CL_MOVI, CL_LUI: begin
        dst_o = imm_zext;
      end
      CL_ADDI, CL_SUBI, CL_CMPI: begin
        src_o = imm_sext;
        dst_o = rdata_a_i;
      end
      CL_ADDUI, CL_ANDI, CL_ORI, CL_XORI: begin
        src_o = imm_zext;
        dst_o = rdata_a_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute controller: accept, read registers, run ALU, write back.
// Ports: start/ready handshake + decoded fields in; register file read/write,
// ALU control/operands out; ALU result/flags in; psr, done, illegal out.
module alu_exec_sequencer
  import alu_isa_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4,
  parameter int IMMW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               ready,
  input  logic [7:0]         op,
  input  logic [REGBITS-1:0] rdest,
  input  logic [REGBITS-1:0] rsrc,
  input  logic [IMMW-1:0]    imm,
  output logic [REGBITS-1:0] rf_raddr_a,
  output logic [REGBITS-1:0] rf_raddr_b,
  input  logic [WIDTH-1:0]   rf_rdata_a,
  input  logic [WIDTH-1:0]   rf_rdata_b,
  output logic               rf_we,
  output logic [REGBITS-1:0] rf_waddr,
  output logic [WIDTH-1:0]   rf_wdata,
  output logic               alu_enable,
  output logic [7:0]         alu_op,
  output logic [WIDTH-1:0]   alu_src,
  output logic [WIDTH-1:0]   alu_dst,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [4:0]         alu_flags,
  output logic [4:0]         psr,
  output logic               done,
  output logic               illegal
);

  state_e             state_q, state_d;
  logic [7:0]         op_q, op_d;
  logic [REGBITS-1:0] rdest_q, rdest_d;
  logic [REGBITS-1:0] rsrc_q, rsrc_d;
  logic [IMMW-1:0]    imm_q, imm_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic [4:0]         psr_q, psr_d;

  logic [WIDTH-1:0]   mux_src;
  logic [WIDTH-1:0]   mux_dst;
  logic               mux_illegal;

  alu_operand_mux #(
    .WIDTH(WIDTH),
    .IMMW (IMMW)
  ) u_operand_mux (
    .op_class_i(op_q[7:4]),
    .imm_i     (imm_q),
    .rdata_a_i (rf_rdata_a),
    .rdata_b_i (rf_rdata_b),
    .src_o     (mux_src),
    .dst_o     (mux_dst),
    .illegal_o (mux_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rdest_q  <= '0;
      rsrc_q   <= '0;
      imm_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      psr_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rdest_q  <= rdest_d;
      rsrc_q   <= rsrc_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      psr_q    <= psr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rdest_d    = rdest_q;
    rsrc_d     = rsrc_q;
    imm_d      = imm_q;
    result_d   = result_q;
    flags_d    = flags_q;
    psr_d      = psr_q;
    ready      = 1'b0;
    alu_enable = 1'b0;
    alu_op     = '0;
    alu_src    = '0;
    alu_dst    = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    rf_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          op_d    = op;
          rdest_d = rdest;
          rsrc_d  = rsrc;
          imm_d   = imm;
          state_d = ST_READ;
        end
      end
      // Addresses are driven from the latched fields; data lands next cycle.
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_op     = op_q;
        alu_enable = !mux_illegal;
        alu_src    = mux_src;
        alu_dst    = mux_dst;
        result_d   = alu_result;
        flags_d    = alu_flags;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        done    = 1'b1;
        illegal = mux_illegal;
        rf_we   = !mux_illegal && !is_cmp(op_q);
        if (!mux_illegal) begin
          psr_d = (psr_q & ~psr_mask(op_q)) | (flags_q & psr_mask(op_q));
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rf_raddr_a = rdest_q;
  assign rf_raddr_b = rsrc_q;
  assign rf_waddr   = rdest_q;
  assign rf_wdata   = result_q;
  assign psr        = psr_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
module tb_alu_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic [7:0]  op;
  logic [3:0]  rdest, rsrc;
  logic [7:0]  imm;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        alu_enable;
  logic [7:0]  alu_op;
  logic [15:0] alu_src, alu_dst, alu_result;
  logic [4:0]  alu_flags, psr;
  logic        done, illegal;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu_exec_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .op(op),
    .rdest(rdest), .rsrc(rsrc), .imm(imm),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_src(alu_src), .alu_dst(alu_dst),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .psr(psr), .done(done), .illegal(illegal)
  );

  // Behavioural ALU: returns {C, L, F, Z, N, result}
  function automatic logic [20:0] alu_fn(input logic [7:0] o, input logic [15:0] d, input logic [15:0] s);
    logic [16:0] sum, dif;
    logic [15:0] r;
    logic c, l, f, z, n, cmp;
    int k;
    sum = {1'b0, d} + {1'b0, s};
    dif = {1'b0, d} - {1'b0, s};
    k = 0;
    case (o[7:4])
      4'h0: case (o[3:0])
              4'h1: k = 1; 4'h2: k = 2; 4'h3: k = 3;
              4'h5, 4'h6, 4'h7: k = 4;
              4'h9, 4'hA: k = 5;
              4'hB: k = 6; 4'hD: k = 7;
              default: k = 0;
            endcase
      4'h1: k = 1; 4'h2: k = 2; 4'h3: k = 3;
      4'h5, 4'h6: k = 4;
      4'h8: k = 9; 4'h9: k = 5; 4'hB: k = 6;
      4'hD: k = 8; 4'hF: k = 10;
      default: k = 0;
    endcase
    r = '0; c = sum[16]; f = 1'b0; cmp = 1'b0;
    case (k)
      1: r = d & s;
      2: r = d | s;
      3: r = d ^ s;
      4: begin r = sum[15:0]; f = (d[15] == s[15]) && (r[15] != d[15]); end
      5: begin r = dif[15:0]; c = dif[16]; f = (d[15] != s[15]) && (r[15] != d[15]); end
      6: begin r = dif[15:0]; c = dif[16]; cmp = 1'b1; end
      7: r = s;
      8: r = d;
      9: r = d << s[3:0];
      10: r = d << 8;
      default: r = '0;
    endcase
    l = d < s;
    z = cmp ? (d == s) : (r == 16'h0);
    n = cmp ? ($signed(d) < $signed(s)) : r[15];
    return {c, l, f, z, n, r};
  endfunction

  always_comb begin
    {alu_flags, alu_result} = alu_enable ? alu_fn(alu_op, alu_dst, alu_src) : 21'd0;
  end

  // Register file: synchronous read, bench-side preload port.
  logic [15:0] regs [16];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_waddr = '0;
  logic [15:0] tb_wdata = '0;
  always @(posedge clk) begin
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    else if (tb_we) regs[tb_waddr] <= tb_wdata;
  end

  // Pulse monitors
  int we_cnt = 0, done_cnt = 0, en_cnt = 0, we_dbl = 0, done_dbl = 0;
  logic prev_we = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (rf_we) we_cnt++;
    if (done) done_cnt++;
    if (alu_enable) en_cnt++;
    if (rf_we && prev_we) we_dbl++;
    if (done && prev_done) done_dbl++;
    prev_we = rf_we;
    prev_done = done;
  end

  // Reference state
  logic [15:0] mregs [16];
  logic [4:0]  mpsr;
  logic [15:0] obs_src;
  logic [3:0]  ext_tab [10] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] v);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
    @(negedge clk);
    tb_we = 1'b0;
    mregs[a] = v;
  endtask

  // Issue one instruction from an idle negedge and check every phase.
  task automatic run_instr(input logic [7:0] t_op, input logic [3:0] t_rd, input logic [3:0] t_rs, input logic [7:0] t_imm);
    logic legal, cmp, we_exp;
    logic [15:0] s, d;
    logic [20:0] fr;
    logic [4:0] mask;
    legal = 1'b1; s = '0; d = '0;
    case (t_op[7:4])
      4'h0, 4'h8:             begin s = mregs[t_rs]; d = mregs[t_rd]; end
      4'hD, 4'hF:             d = 16'(t_imm);
      4'h5, 4'h9, 4'hB:       begin s = 16'($signed(t_imm)); d = mregs[t_rd]; end
      4'h6, 4'h1, 4'h2, 4'h3: begin s = 16'(t_imm); d = mregs[t_rd]; end
      default:                legal = 1'b0;
    endcase
    cmp = (t_op == 8'h0B) || (t_op[7:4] == 4'hB);
    we_exp = legal && !cmp;
    fr = alu_fn(t_op, d, s);
    mask = 5'b0;
    if (!legal) mask = 5'b0;
    else if (cmp) mask = 5'b01011;
    else if (t_op == 8'h05 || t_op == 8'h09 || t_op[7:4] == 4'h5 || t_op[7:4] == 4'h9) mask = 5'b10101;
    else if (t_op == 8'h06 || t_op == 8'h07 || t_op[7:4] == 4'h6) mask = 5'b10000;

    check("idle_ready", ready, 1);
    start = 1'b1; op = t_op; rdest = t_rd; rsrc = t_rs; imm = t_imm;
    @(negedge clk);
    start = 1'b0; op = $urandom; rdest = $urandom; rsrc = $urandom; imm = $urandom;
    check("c1_ready", ready, 0);
    check("c1_done", done, 0);
    check("c1_raddr", {rf_raddr_a, rf_raddr_b}, {t_rd, t_rs});
    @(negedge clk);
    check("c2_alu_en", alu_enable, legal);
    check("c2_alu_op", alu_op, t_op);
    check("c2_done", done, 0);
    obs_src = alu_src;
    if (legal) check("c2_operands", {alu_dst, alu_src}, {d, s});
    @(negedge clk);
    check("c3_done", done, 1);
    check("c3_illegal", illegal, !legal);
    check("c3_rf_we", rf_we, we_exp);
    if (we_exp) check("c3_wb", {rf_waddr, rf_wdata}, {t_rd, fr[15:0]});
    @(negedge clk);
    if (we_exp) mregs[t_rd] = fr[15:0];
    mpsr = (mpsr & ~mask) | (fr[20:16] & mask);
    check("psr", psr, mpsr);
    check("post_pulses", {done, rf_we, alu_enable}, 3'b000);
    check("reg_dest", regs[t_rd], mregs[t_rd]);
  endtask

  initial begin
    int w0, d0, e0;
    logic [9:0] rdy_mask;
    logic [3:0] cls, ext;
    reset = 1'b1; start = 1'b0; op = '0; rdest = '0; rsrc = '0; imm = '0;
    mpsr = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_psr", psr, 0);
    check("rst_pulses", {done, illegal, rf_we, alu_enable}, 4'b0);
    check("rst_outs", {rf_waddr, rf_wdata, alu_op, alu_src, alu_dst}, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));

    // ADD overflow
    set_reg(4'd3, 16'h7FFF);
    set_reg(4'd4, 16'h0001);
    run_instr(8'h05, 4'd3, 4'd4, 8'h00);
    check("add_r3", regs[3], 16'h8000);
    check("add_psr", psr, 5'b00101);

    // ADDI with sign-extended immediate
    set_reg(4'd2, 16'h0010);
    run_instr(8'h50, 4'd2, 4'd0, 8'hFF);
    check("addi_src", obs_src, 16'hFFFF);
    check("addi_r2", regs[2], 16'h000F);
    check("addi_psr", psr, 5'b10000);

    // CMPI equal: no writeback, Z set, C/F kept
    set_reg(4'd5, 16'h0004);
    w0 = we_cnt;
    run_instr(8'hB0, 4'd5, 4'd0, 8'h04);
    check("cmpi_no_we", we_cnt - w0, 0);
    check("cmpi_psr", psr, 5'b10010);

    // Illegal class
    w0 = we_cnt; e0 = en_cnt;
    run_instr(8'hC0, 4'd6, 4'd1, 8'h11);
    check("illegal_no_we", we_cnt - w0, 0);
    check("illegal_no_en", en_cnt - e0, 0);
    check("illegal_psr", psr, 5'b10010);

    // Reset in the middle of an ADD's EXEC cycle
    w0 = we_cnt; d0 = done_cnt;
    start = 1'b1; op = 8'h05; rdest = 4'd3; rsrc = 4'd4; imm = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_exec", alu_enable, 1);
    reset = 1'b1;
    #1;
    mpsr = '0;
    check("midrst_ready", ready, 1);
    check("midrst_psr", psr, 0);
    check("midrst_pulses", {done, rf_we, alu_enable}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_we", we_cnt - w0, 0);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_r3", regs[3], mregs[3]);

    // start held high: accepts at cycles 0, 4, 8
    set_reg(4'd7, 16'h1234);
    w0 = we_cnt; d0 = done_cnt; rdy_mask = '0;
    start = 1'b1; op = 8'hD0; rdest = 4'd7; rsrc = 4'd1; imm = 8'h2A;
    for (int c = 0; c < 10; c++) begin
      rdy_mask[c] = ready;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    mregs[7] = 16'h002A;
    check("hold_ready_pattern", rdy_mask, 10'b01_0001_0001);
    check("hold_we_count", we_cnt - w0, 3);
    check("hold_done_count", done_cnt - d0, 3);
    check("hold_r7", regs[7], 16'h002A);
    check("hold_psr", psr, mpsr);

    // Randomized instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      cls = 4'($urandom);
      ext = (cls == 4'h0) ? ext_tab[$urandom_range(0, 9)] : 4'($urandom);
      run_instr({cls, ext}, 4'($urandom), 4'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) check("final_regs", regs[i], mregs[i]);

    check("we_single_cycle", we_dbl, 0);
    check("done_single_cycle", done_dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle execute controller for the 16-bit core.
- Accepts one decoded ALU instruction through a start/ready handshake and reads operands from the register file.
- Drives the combinational ALU's operand, control and enable inputs, captures the result and flags, writes the result back, and keeps the processor status flags.
- Sits between the decoder and the ALU/register file. It is the only master of the ALU control inputs.

Parameters:
- WIDTH, 16, datapath width
- REGBITS, 4, register address bits (16 registers)
- IMMW, 8, immediate field width

Ports:
- clk  in  1  the single clock
- reset  in  1  asynchronous, active-high
- start  in  1  instruction valid
- ready  out  1  sequencer idle; an instruction is accepted on start&&ready
- op  in  8  opcode: [7:4] class, [3:0] ext; same encoding the ALU decodes
- rdest  in  REGBITS  destination/second-operand register
- rsrc  in  REGBITS  source register
- imm  in  IMMW  immediate
- rf_raddr_a  out  REGBITS  read address, dest operand
- rf_raddr_b  out  REGBITS  read address, src operand
- rf_rdata_a  in  WIDTH  synchronous read data, valid 1 cycle after address
- rf_rdata_b  in  WIDTH  synchronous read data, valid 1 cycle after address
- rf_we  out  1  write-back strobe
- rf_waddr  out  REGBITS  write address
- rf_wdata  out  WIDTH  write data
- alu_enable  out  1  ALU result enable
- alu_op  out  8  ALU operationControl
- alu_src  out  WIDTH  ALU sourceData
- alu_dst  out  WIDTH  ALU destData
- alu_result  in  WIDTH  ALU result
- alu_flags  in  5  {carry, low, overflow, zero, negative} from the ALU
- psr  out  5  registered flags {C, L, F, Z, N}
- done  out  1  one-cycle pulse when the instruction retires
- illegal  out  1  valid with done; opcode unsupported

Behaviour:
- Reset (asynchronous):
  - state=IDLE; ready=1.
  - psr, done, illegal, rf_we, alu_enable = 0.
  - All latched fields and address/data outputs = 0.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE: on start&&ready, latch op/rdest/rsrc/imm and go to READ; ready drops the next cycle. A start while not ready is ignored and not queued.
- READ (1 cycle): rf_raddr_a=rdest, rf_raddr_b=rsrc. Go to EXEC.
- EXEC (1 cycle): drive alu_op=latched op and alu_enable=1; register alu_result into a result register and alu_flags into a flag register. Go to WRITE.
  - Operand steering by op[7:4]:
    - 0000 (RTYPE), 1000 (SHIFT): alu_src=rf_rdata_b, alu_dst=rf_rdata_a.
    - 1101 (MOVI), 1111 (LUI): alu_dst=zero-extended imm, alu_src=0.
    - 0101 (ADDI), 1001 (SUBI), 1011 (CMPI): alu_src=sign-extended imm, alu_dst=rf_rdata_a.
    - 0110 (ADDUI), 0001 (ANDI), 0010 (ORI), 0011 (XORI): alu_src=zero-extended imm, alu_dst=rf_rdata_a.
    - Any other class (0100, 1010, 1100, 1110, 0111): illegal; ALU not enabled; no writeback.
- WRITE (1 cycle): done=1; illegal=1 if illegal. rf_we=1 unless illegal or op is CMP (0000_1011) or CMPI (1011_xxxx). rf_waddr=rdest, rf_wdata=latched result. Go to IDLE; ready=1 the following cycle.
- Latency: 3 cycles from accept to done. Throughput: 1 instruction per 4 cycles.
- psr update at the WRITE edge, only for the fields listed; all other fields hold their value:
  - CMP/CMPI: L, Z, N.
  - ADD/ADDI/SUB/SUBI: C, F, N.
  - ADDU/ADDUI/ADDC: C.
  - Logic, MOV/MOVI, LUI, shifts and illegal ops: no change.
- Outside EXEC: alu_enable=0 and alu_op=0.
- rf_we and done are strictly single-cycle pulses.
- Reset asserted mid-operation: immediate return to IDLE; no rf_we and no done are emitted for the aborted instruction; psr cleared.
- Immediate extension: sign extension copies imm[IMMW-1] into the upper bits; zero extension fills them with 0.

Decomposition:
- Shared package alu_isa_pkg:
  - class and ext opcode constants (RTYPE, ADDI … LUI; ADD … MOV, shift codes)
  - FSM state enum
  - flag bit index constants C=4, L=3, F=2, Z=1, N=0
- One natural sub-module, alu_operand_mux: combinational steering and immediate extension, plus the illegal decode.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset mid-EXEC of ADD (op 0x05): assert reset -> state IDLE, ready=1, psr=0, no rf_we pulse.
- R3=0x7FFF, R4=0x0001; ADD (op 0x05, rdest=3, rsrc=4) -> done 3 cycles after accept; R3 written 0x8000; psr F=1, C=0, N=1.
- R2=0x0010; ADDI (op 0x50, rdest=2, imm=0xFF) -> alu_src=0xFFFF; R2 written 0x000F; C=1.
- R5=0x0004; CMPI (op 0xB0, rdest=5, imm=0x04) -> rf_we never asserted; psr Z=1, L=0; C/F unchanged.
- Illegal op 0xC0 -> done=1 with illegal=1 at cycle 3; no rf_we; alu_enable never high; psr unchanged.
- start held high continuously for 10 cycles with MOVI (op 0xD0, imm=0x2A) -> exactly 3 instructions accepted at cycles 0, 4 and 8; ready low during each busy window; R[rdest] written 0x002A each time.
